// File: rtl/dispatch_rob_alloc.sv
// Two-wide dispatch stage feeding the ROB and issue queue through a one-pair skid register.
// Optional stall counters are enabled by defining DISP_PERF_CNT_EN.
module dispatch_rob_alloc #(
  parameter int DATA_WIDTH  = 124,
  parameter int DEPTH       = 64,
  parameter int INDEX_WIDTH = 7
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rn2disp_valid0,
  input  logic                   rn2disp_valid1,
  input  logic [DATA_WIDTH-1:0]  rn2disp_data0,
  input  logic [DATA_WIDTH-1:0]  rn2disp_data1,
  output logic                   disp2rn_ready,
  input  logic [INDEX_WIDTH-1:0] rob2disp_instr_cnt,
  input  logic [INDEX_WIDTH-1:0] rob2disp_instr_id,
  input  logic                   rob_is_idle,
  input  logic                   flush_valid,
  output logic                   disp2rob_wr_en0,
  output logic                   disp2rob_wr_en1,
  output logic [DATA_WIDTH-1:0]  disp2rob_wr_data0,
  output logic [DATA_WIDTH-1:0]  disp2rob_wr_data1,
  output logic                   disp2isq_valid0,
  output logic                   disp2isq_valid1,
  output logic [DATA_WIDTH-1:0]  disp2isq_data0,
  output logic [DATA_WIDTH-1:0]  disp2isq_data1,
  output logic [INDEX_WIDTH-1:0] disp2isq_id0,
  output logic [INDEX_WIDTH-1:0] disp2isq_id1,
  input  logic                   isq2disp_ready
`ifdef DISP_PERF_CNT_EN
  ,
  output logic [31:0]            perf_rob_full_stall,
  output logic [31:0]            perf_isq_stall,
  output logic [31:0]            perf_flush_stall
`endif
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH,
    ST_WAIT_IDLE
  } state_t;

  localparam logic [INDEX_WIDTH:0] DEPTH_EXT = (INDEX_WIDTH + 1)'(DEPTH);

  state_t                 r_state;
  logic                   r_buf_valid;
  logic [1:0]             r_buf_cnt;
  logic [DATA_WIDTH-1:0]  r_buf_data0;
  logic [DATA_WIDTH-1:0]  r_buf_data1;

  logic [INDEX_WIDTH:0]   w_cnt_ext;
  logic [INDEX_WIDTH:0]   w_free;
  logic [INDEX_WIDTH:0]   w_need;
  logic                   w_run;
  logic                   w_rob_full;
  logic                   w_fire;
  logic                   w_accept;
  logic                   w_pair;

  // A count above DEPTH means the ROB view is stale; treat it as no room at all.
  assign w_cnt_ext  = {1'b0, rob2disp_instr_cnt};
  assign w_free     = (w_cnt_ext > DEPTH_EXT) ? '0 : (DEPTH_EXT - w_cnt_ext);
  assign w_need     = {{(INDEX_WIDTH - 1){1'b0}}, r_buf_cnt};
  assign w_run      = (r_state == ST_RUN);
  assign w_rob_full = r_buf_valid && (w_free < w_need);
  assign w_pair     = (r_buf_cnt == 2'd2);

  assign w_fire = !reset && w_run && r_buf_valid && isq2disp_ready &&
                  !w_rob_full && !flush_valid;

  assign disp2rn_ready = w_run && !reset && !flush_valid && (!r_buf_valid || w_fire);
  assign w_accept      = disp2rn_ready && rn2disp_valid0;

  assign disp2rob_wr_en0   = w_fire;
  assign disp2rob_wr_en1   = w_fire && w_pair;
  assign disp2rob_wr_data0 = r_buf_data0;
  assign disp2rob_wr_data1 = r_buf_data1;

  assign disp2isq_valid0 = w_fire;
  assign disp2isq_valid1 = w_fire && w_pair;
  assign disp2isq_data0  = r_buf_data0;
  assign disp2isq_data1  = r_buf_data1;
  assign disp2isq_id0    = rob2disp_instr_id;
  assign disp2isq_id1    = rob2disp_instr_id + INDEX_WIDTH'(1);

  // A flush in any state restarts the FLUSH/WAIT_IDLE sequence and drops the buffer.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_buf_valid <= 1'b0;
      r_buf_cnt   <= 2'd1;
      r_buf_data0 <= '0;
      r_buf_data1 <= '0;
    end else if (flush_valid) begin
      r_state     <= ST_FLUSH;
      r_buf_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_accept) begin
            r_buf_valid <= 1'b1;
            r_buf_cnt   <= rn2disp_valid1 ? 2'd2 : 2'd1;
            r_buf_data0 <= rn2disp_data0;
            r_buf_data1 <= rn2disp_data1;
          end else if (w_fire) begin
            r_buf_valid <= 1'b0;
          end
        end
        ST_FLUSH: begin
          r_state     <= ST_WAIT_IDLE;
          r_buf_valid <= 1'b0;
        end
        ST_WAIT_IDLE: begin
          r_buf_valid <= 1'b0;
          if (rob_is_idle) begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_state     <= ST_RUN;
          r_buf_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef DISP_PERF_CNT_EN
  logic [31:0] r_perf_rob_full;
  logic [31:0] r_perf_isq;
  logic [31:0] r_perf_flush;

  // Saturating counters; an ISQ stall is only charged when the ROB had room.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_perf_rob_full <= '0;
      r_perf_isq      <= '0;
      r_perf_flush    <= '0;
    end else begin
      if (w_rob_full && (r_perf_rob_full != '1)) begin
        r_perf_rob_full <= r_perf_rob_full + 32'd1;
      end
      if (r_buf_valid && !isq2disp_ready && !w_rob_full && (r_perf_isq != '1)) begin
        r_perf_isq <= r_perf_isq + 32'd1;
      end
      if (!w_run && (r_perf_flush != '1)) begin
        r_perf_flush <= r_perf_flush + 32'd1;
      end
    end
  end

  assign perf_rob_full_stall = r_perf_rob_full;
  assign perf_isq_stall      = r_perf_isq;
  assign perf_flush_stall    = r_perf_flush;
`endif

endmodule
